// File: rtl/emu_pkg.sv
// Shared definitions for the emulator register file and its debug/trace helpers.
//   NUM_REGS     registers in the file
//   REG_WIDTH    register data width
//   CAR_REG_IDX  index of the carry register
//   dump_state_t state encoding of the register dump reader
package emu_pkg;

    localparam int unsigned NUM_REGS    = 13;
    localparam int unsigned REG_WIDTH   = 8;
    localparam int unsigned CAR_REG_IDX = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Register dump reader: on start, walks register addresses first..NUM_REGS-1 through
// a combinational read port and streams each (address, value) pair on a valid/ready port.
// Never writes registers.
// Ports:
//   clk        clock, all state on posedge
//   reset      asynchronous active-high reset
//   start      begin a dump (honoured only when idle)
//   abort      synchronous cancel of a dump in progress
//   rf_addr    register-file read address (registered pointer, driven in every state)
//   rf_data    combinational read data for rf_addr
//   out_valid  out_addr/out_data hold a word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_addr   register index of the current word
//   out_data   register value of the current word
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last word is accepted
module reg_dump_reader #(
    parameter int unsigned NUM_REGS  = emu_pkg::NUM_REGS,
    parameter int unsigned REG_WIDTH = emu_pkg::REG_WIDTH,
    parameter bit          SKIP_R0   = 1'b1,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rf_addr,
    input  logic [REG_WIDTH-1:0] rf_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [REG_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    import emu_pkg::*;

    // r0 is hard zero, so it is normally not worth sending.
    localparam logic [ADDR_W-1:0] FIRST_ADDR = SKIP_R0 ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    dump_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q;
    logic [ADDR_W-1:0]    out_addr_q;
    logic [REG_WIDTH-1:0] out_data_q;
    logic                 handshake;
    logic                 last_word;

    assign handshake = out_valid && out_ready;
    assign last_word = (ptr_q == LAST_ADDR);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort beats start and any simultaneous handshake.
    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start && !abort) state_d = READ;
                READ: state_d = HOLD;
                HOLD: if (handshake) state_d = last_word ? FIN : READ;
                FIN:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; a word is on offer exactly while in HOLD.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: busy      = 1'b0;
            READ: ;
            HOLD: out_valid = 1'b1;
            FIN:  done      = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

    // Address pointer and output word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else if (!abort) begin
            if (state_q == IDLE && start) begin
                ptr_q <= FIRST_ADDR;
            end
            if (state_q == READ) begin
                out_addr_q <= ptr_q;
                out_data_q <= rf_data;
            end
            // Pointer stops at the last register; it never wraps.
            if (state_q == HOLD && handshake && !last_word) begin
                ptr_q <= ptr_q + ADDR_W'(1);
            end
        end
    end

    assign rf_addr  = ptr_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    localparam int NREGS = 13;
    localparam int AW    = 4;
    localparam int DW    = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } word_t;

    typedef struct {
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] preload;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
    logic [AW-1:0] rf_addr0, rf_addr1, out_addr0, out_addr1;
    logic [DW-1:0] rf_data0, rf_data1, out_data0, out_data1;
    logic valid0, valid1, busy0, busy1, done0, done1;

    logic [DW-1:0] rf [0:15];
    assign rf_data0 = rf[rf_addr0];
    assign rf_data1 = rf[rf_addr1];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    word_t q0[$];
    word_t q1[$];
    int done_cnt0 = 0, done_cnt1 = 0;
    int hs_cyc0 = 0, done_cyc0 = 0;
    vec_t vec [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_dump_reader #(.SKIP_R0(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .rf_addr(rf_addr0), .rf_data(rf_data0), .out_valid(valid0), .out_ready(ready0),
        .out_addr(out_addr0), .out_data(out_data0), .busy(busy0), .done(done0)
    );

    reg_dump_reader #(.SKIP_R0(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rf_addr(rf_addr1), .rf_data(rf_data1), .out_valid(valid1), .out_ready(ready1),
        .out_addr(out_addr1), .out_data(out_data1), .busy(busy1), .done(done1)
    );

    // Handshake/done monitor, sampled mid-cycle; a valid&&ready seen here completes at the
    // following posedge.
    always @(negedge clk) begin
        if (valid0 && ready0) begin
            q0.push_back('{out_addr0, out_data0});
            hs_cyc0 = cyc;
        end
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (valid1 && ready1) q1.push_back('{out_addr1, out_data1});
        if (done1) done_cnt1++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        done_cnt0 = 0;
        done_cnt1 = 0;
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        for (int i = 0; i < 12; i++) rf[vec[i].exp_addr] = vec[i].preload;
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Step until dut0 offers a word at addr; ok reports whether it appeared in time.
    task automatic wait_word0(input logic [AW-1:0] addr, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            if (valid0 && out_addr0 == addr) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done0(input int budget);
        for (int n = 0; n < budget && done_cnt0 == 0; n++) tick();
        tick();
    endtask

    task automatic check_words0(input string name, input logic [7:0] r7, input logic [7:0] r3);
        logic [7:0] exp;
        check({name, " count"}, q0.size(), 12);
        for (int i = 0; i < 12 && i < q0.size(); i++) begin
            exp = vec[i].exp_data;
            if (vec[i].exp_addr == 4'd7) exp = r7;
            if (vec[i].exp_addr == 4'd3) exp = r3;
            check($sformatf("%s addr[%0d]", name, i), q0[i].addr, vec[i].exp_addr);
            check($sformatf("%s data[%0d]", name, i), q0[i].data, exp);
        end
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 12; i++) begin
            vec[i].exp_addr = AW'(i + 1);
            vec[i].preload  = DW'((i + 1) * 8'h11);
            vec[i].exp_data = DW'((i + 1) * 8'h11);
        end
        preload();

        // Reset state
        reset = 1'b1;
        #2;
        check("reset rf_addr", rf_addr0, 0);
        check("reset out_addr", out_addr0, 0);
        check("reset out_data", out_data0, 0);
        check("reset out_valid", valid0, 0);
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        tick();
        reset = 1'b0;
        tick();

        // Start and abort together in IDLE: stay idle
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("start+abort idle busy", busy0, 0);
        tick();
        check("start+abort idle valid", valid0, 0);

        // Test 1: full dump with ready held high, latency and done timing
        clear_mon();
        ready0 = 1'b1;
        pulse_start0();
        check("busy after start", busy0, 1);
        check("rf_addr first", rf_addr0, 1);
        check("valid in READ", valid0, 0);
        tick();
        check("first valid", valid0, 1);
        check("first addr", out_addr0, 1);
        check("first data", out_data0, 8'h11);
        wait_done0(100);
        check_words0("t1", 8'h77, 8'h33);
        check("t1 done count", done_cnt0, 1);
        check("t1 done latency", done_cyc0 - hs_cyc0, 1);
        check("t1 idle after", busy0, 0);

        // Test 2: stall on addr 4 for five cycles
        clear_mon();
        pulse_start0();
        wait_word0(4'd4, 50, ok);
        check("t2 reached addr4", ok, 1);
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2 stall valid %0d", i), valid0, 1);
            check($sformatf("t2 stall addr %0d", i), out_addr0, 4);
            check($sformatf("t2 stall data %0d", i), out_data0, 8'h44);
        end
        ready0 = 1'b1;
        wait_done0(100);
        check_words0("t2", 8'h77, 8'h33);
        check("t2 done count", done_cnt0, 1);

        // Test 3: SKIP_R0=0 instance, 13 words from r0
        clear_mon();
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int n = 0; n < 100 && done_cnt1 == 0; n++) tick();
        tick();
        check("t3 count", q1.size(), 13);
        if (q1.size() > 0) begin
            check("t3 first addr", q1[0].addr, 0);
            check("t3 first data", q1[0].data, 8'h00);
        end
        if (q1.size() == 13) begin
            check("t3 last addr", q1[12].addr, 12);
            check("t3 last data", q1[12].data, 8'hCC);
        end
        check("t3 done count", done_cnt1, 1);
        ready1 = 1'b0;

        // Test 4: live register writes during the walk
        clear_mon();
        pulse_start0();
        for (int n = 0; n < 100 && done_cnt0 == 0; n++) begin
            if (valid0 && out_addr0 == 4'd4) rf[3] = 8'h99;
            if (valid0 && out_addr0 == 4'd5) rf[7] = 8'h5A;
            tick();
        end
        tick();
        check_words0("t4", 8'h5A, 8'h33);
        check("t4 done count", done_cnt0, 1);
        preload();

        // Test 5: abort while holding addr 6, then restart from addr 1
        clear_mon();
        pulse_start0();
        wait_word0(4'd6, 50, ok);
        check("t5 reached addr6", ok, 1);
        ready0 = 1'b0;
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("t5 abort valid", valid0, 0);
        check("t5 abort busy", busy0, 0);
        tick();
        tick();
        check("t5 no done", done_cnt0, 0);
        clear_mon();
        ready0 = 1'b1;
        pulse_start0();
        wait_done0(100);
        check_words0("t5 restart", 8'h77, 8'h33);

        // Test 6a: asynchronous reset between edges mid-dump
        clear_mon();
        pulse_start0();
        wait_word0(4'd5, 50, ok);
        check("t6 reached addr5", ok, 1);
        #3;
        reset = 1'b1;
        #1;
        check("t6 reset valid", valid0, 0);
        check("t6 reset busy", busy0, 0);
        check("t6 reset out_addr", out_addr0, 0);
        check("t6 reset out_data", out_data0, 0);
        check("t6 reset rf_addr", rf_addr0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check("t6 no done", done_cnt0, 0);

        // Test 6b: start pulse while busy is ignored
        clear_mon();
        pulse_start0();
        tick();
        tick();
        tick();
        pulse_start0();
        wait_done0(100);
        check_words0("t6 busy start", 8'h77, 8'h33);
        check("t6 done count", done_cnt0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
